// File: rtl/decode_control_stage_pkg.sv
// Shared encodings for the BRISC-V decode/execute boundary: opcodes, ALU
// operation codes, select encodings and the bundled control word.
package decode_control_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_R      = 3'b000;
  localparam logic [2:0] ALU_I      = 3'b001;
  localparam logic [2:0] ALU_BRANCH = 3'b010;
  localparam logic [2:0] ALU_JAL    = 3'b011;
  localparam logic [2:0] ALU_LOAD   = 3'b100;
  localparam logic [2:0] ALU_STORE  = 3'b101;
  localparam logic [2:0] ALU_UPPER  = 3'b110;
  localparam logic [2:0] ALU_JALR   = 3'b111;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_PC4  = 2'b10;
  localparam logic [1:0] OPA_ZERO = 2'b11;

  localparam logic [1:0] EXT_I = 2'b00;
  localparam logic [1:0] EXT_S = 2'b01;
  localparam logic [1:0] EXT_U = 2'b10;

  typedef struct packed {
    logic       branch_op;
    logic       mem_read;
    logic       memto_reg;
    logic       mem_write;
    logic       operand_b_sel;
    logic       reg_write;
    logic [2:0] alu_op;
    logic [1:0] next_pc_sel;
    logic [1:0] operand_a_sel;
    logic [1:0] extend_sel;
  } ctrl_t;

endpackage

// File: rtl/decode_control_stage_control_decoder.sv
// Purely combinational RV32I opcode-to-control decode; unknown opcodes
// decode to an all-zero control word (NOP, no trap).
module decode_control_stage_control_decoder
  import decode_control_stage_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op    = ALU_R;
        ctrl.reg_write = 1'b1;
      end
      OP_I: begin
        ctrl.alu_op        = ALU_I;
        ctrl.operand_b_sel = 1'b1;
        ctrl.reg_write     = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_op        = ALU_LOAD;
        ctrl.mem_read      = 1'b1;
        ctrl.memto_reg     = 1'b1;
        ctrl.operand_b_sel = 1'b1;
        ctrl.reg_write     = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_op        = ALU_STORE;
        ctrl.mem_write     = 1'b1;
        ctrl.operand_b_sel = 1'b1;
        ctrl.extend_sel    = EXT_S;
      end
      OP_BRANCH: begin
        ctrl.alu_op      = ALU_BRANCH;
        ctrl.branch_op   = 1'b1;
        ctrl.next_pc_sel = NPC_BRANCH;
      end
      OP_JAL: begin
        ctrl.alu_op        = ALU_JAL;
        ctrl.operand_a_sel = OPA_PC4;
        ctrl.next_pc_sel   = NPC_JAL;
        ctrl.reg_write     = 1'b1;
      end
      OP_JALR: begin
        ctrl.alu_op        = ALU_JALR;
        ctrl.operand_a_sel = OPA_PC4;
        ctrl.next_pc_sel   = NPC_JALR;
        ctrl.reg_write     = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op        = ALU_UPPER;
        ctrl.operand_a_sel = OPA_ZERO;
        ctrl.operand_b_sel = 1'b1;
        ctrl.extend_sel    = EXT_U;
        ctrl.reg_write     = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.alu_op        = ALU_UPPER;
        ctrl.operand_a_sel = OPA_PC;
        ctrl.operand_b_sel = 1'b1;
        ctrl.extend_sel    = EXT_U;
        ctrl.reg_write     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_control_stage.sv
// Decode/execute boundary: decodes control from the opcode and holds the
// ID/EX pipeline register with reset > flush > stall > capture priority.
module decode_control_stage
  import decode_control_stage_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [DATA_WIDTH-1:0]   rs1_data,
  input  logic [DATA_WIDTH-1:0]   rs2_data,
  input  logic [4:0]              rd,
  input  logic [DATA_WIDTH-1:0]   extend_imm,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic [ADDRESS_BITS-1:0] JAL_target,
  input  logic [ADDRESS_BITS-1:0] inst_PC,
  output logic [1:0]              extend_sel,
  output logic [DATA_WIDTH-1:0]   reg_rs1_data,
  output logic [DATA_WIDTH-1:0]   reg_rs2_data,
  output logic [DATA_WIDTH-1:0]   reg_extend_imm,
  output logic [4:0]              reg_rd,
  output logic [6:0]              reg_opcode,
  output logic [6:0]              reg_funct7,
  output logic [2:0]              reg_funct3,
  output logic [ADDRESS_BITS-1:0] reg_branch_target,
  output logic [ADDRESS_BITS-1:0] reg_JAL_target,
  output logic [ADDRESS_BITS-1:0] reg_inst_PC,
  output logic                    reg_branch_op,
  output logic                    reg_memRead,
  output logic                    reg_memtoReg,
  output logic                    reg_memWrite,
  output logic                    reg_operand_B_sel,
  output logic                    reg_regWrite,
  output logic [2:0]              reg_ALUOp,
  output logic [1:0]              reg_next_PC_sel,
  output logic [1:0]              reg_operand_A_sel,
  output logic [1:0]              reg_extend_sel
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [DATA_WIDTH-1:0]   extend_imm;
    logic [4:0]              rd;
    logic [6:0]              opcode;
    logic [6:0]              funct7;
    logic [2:0]              funct3;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic [ADDRESS_BITS-1:0] jal_target;
    logic [ADDRESS_BITS-1:0] inst_pc;
  } idex_data_t;

  ctrl_t      ctrl;
  ctrl_t      ctrl_d, ctrl_q;
  idex_data_t data_d, data_q;

  // The core index only tags the instance; it never alters behaviour.
  logic core_unused;
  assign core_unused = (CORE != 0);

  decode_control_stage_control_decoder u_control_decoder (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign extend_sel = ctrl.extend_sel;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush) begin
      ctrl_d = '0;
      data_d = '0;
    end else if (!stall) begin
      ctrl_d               = ctrl;
      data_d.rs1_data      = rs1_data;
      data_d.rs2_data      = rs2_data;
      data_d.extend_imm    = extend_imm;
      data_d.rd            = rd;
      data_d.opcode        = opcode;
      data_d.funct7        = funct7;
      data_d.funct3        = funct3;
      data_d.branch_target = branch_target;
      data_d.jal_target    = JAL_target;
      data_d.inst_pc       = inst_PC;
    end
  end

  // ID/EX stage boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign reg_rs1_data      = data_q.rs1_data;
  assign reg_rs2_data      = data_q.rs2_data;
  assign reg_extend_imm    = data_q.extend_imm;
  assign reg_rd            = data_q.rd;
  assign reg_opcode        = data_q.opcode;
  assign reg_funct7        = data_q.funct7;
  assign reg_funct3        = data_q.funct3;
  assign reg_branch_target = data_q.branch_target;
  assign reg_JAL_target    = data_q.jal_target;
  assign reg_inst_PC       = data_q.inst_pc;

  assign reg_branch_op     = ctrl_q.branch_op;
  assign reg_memRead       = ctrl_q.mem_read;
  assign reg_memtoReg      = ctrl_q.memto_reg;
  assign reg_memWrite      = ctrl_q.mem_write;
  assign reg_operand_B_sel = ctrl_q.operand_b_sel;
  assign reg_regWrite      = ctrl_q.reg_write;
  assign reg_ALUOp         = ctrl_q.alu_op;
  assign reg_next_PC_sel   = ctrl_q.next_pc_sel;
  assign reg_operand_A_sel = ctrl_q.operand_a_sel;
  assign reg_extend_sel    = ctrl_q.extend_sel;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage: decode table, ID/EX capture,
// stall hold, flush bubble and reset priority.
module tb_decode_control_stage;

  localparam int DW = 32;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset, stall, flush;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [DW-1:0] rs1_data, rs2_data, extend_imm;
  logic [4:0]    rd;
  logic [AW-1:0] branch_target, JAL_target, inst_PC;
  logic [1:0]    extend_sel;
  logic [DW-1:0] reg_rs1_data, reg_rs2_data, reg_extend_imm;
  logic [4:0]    reg_rd;
  logic [6:0]    reg_opcode, reg_funct7;
  logic [2:0]    reg_funct3;
  logic [AW-1:0] reg_branch_target, reg_JAL_target, reg_inst_PC;
  logic          reg_branch_op, reg_memRead, reg_memtoReg, reg_memWrite;
  logic          reg_operand_B_sel, reg_regWrite;
  logic [2:0]    reg_ALUOp;
  logic [1:0]    reg_next_PC_sel, reg_operand_A_sel, reg_extend_sel;

  int errors = 0;
  int checks = 0;

  // {branch, memRead, memtoReg, memWrite, B, regWrite, ALUOp, nextPC, A, ext}
  logic [14:0] got_ctrl;
  logic [DW*3+5+7+7+3+AW*3-1:0] got_data;
  assign got_ctrl = {reg_branch_op, reg_memRead, reg_memtoReg, reg_memWrite,
                     reg_operand_B_sel, reg_regWrite, reg_ALUOp,
                     reg_next_PC_sel, reg_operand_A_sel, reg_extend_sel};
  assign got_data = {reg_rs1_data, reg_rs2_data, reg_extend_imm, reg_rd,
                     reg_opcode, reg_funct7, reg_funct3, reg_branch_target,
                     reg_JAL_target, reg_inst_PC};

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                     7'b0100011, 7'b1100011, 7'b1101111,
                                     7'b1100111, 7'b0110111, 7'b0010111};
  localparam logic [14:0] EXP [9] = '{
    15'b0_0_0_0_0_1_000_00_00_00,  // R
    15'b0_0_0_0_1_1_001_00_00_00,  // I
    15'b0_1_1_0_1_1_100_00_00_00,  // load
    15'b0_0_0_1_1_0_101_00_00_01,  // store
    15'b1_0_0_0_0_0_010_01_00_00,  // branch
    15'b0_0_0_0_0_1_011_10_10_00,  // JAL
    15'b0_0_0_0_0_1_111_11_10_00,  // JALR
    15'b0_0_0_0_1_1_110_00_11_10,  // LUI
    15'b0_0_0_0_1_1_110_00_01_10   // AUIPC
  };

  decode_control_stage #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
    .extend_imm(extend_imm), .branch_target(branch_target),
    .JAL_target(JAL_target), .inst_PC(inst_PC), .extend_sel(extend_sel),
    .reg_rs1_data(reg_rs1_data), .reg_rs2_data(reg_rs2_data),
    .reg_extend_imm(reg_extend_imm), .reg_rd(reg_rd),
    .reg_opcode(reg_opcode), .reg_funct7(reg_funct7), .reg_funct3(reg_funct3),
    .reg_branch_target(reg_branch_target), .reg_JAL_target(reg_JAL_target),
    .reg_inst_PC(reg_inst_PC), .reg_branch_op(reg_branch_op),
    .reg_memRead(reg_memRead), .reg_memtoReg(reg_memtoReg),
    .reg_memWrite(reg_memWrite), .reg_operand_B_sel(reg_operand_B_sel),
    .reg_regWrite(reg_regWrite), .reg_ALUOp(reg_ALUOp),
    .reg_next_PC_sel(reg_next_PC_sel), .reg_operand_A_sel(reg_operand_A_sel),
    .reg_extend_sel(reg_extend_sel)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    opcode = 7'b0100011; funct3 = 3'h5; funct7 = 7'h20;
    rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd = 5'd9;
    extend_imm = 32'hFFFF_FFF0; branch_target = 20'hABCDE;
    JAL_target = 20'h12345; inst_PC = 20'h00400;
    tick();
    tick();
    checks++;
    if (got_ctrl !== 15'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", got_ctrl);
    end
    checks++;
    if (got_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", got_data);
    end
    checks++;
    if (extend_sel !== 2'b01) begin
      errors++;
      $display("FAIL reset_extend_sel: got %b expected 01", extend_sel);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    opcode = 7'b0110011; rs1_data = 32'd5; rs2_data = 32'd7; rd = 5'd3;
    tick();
    checks++;
    if ({reg_rs1_data, reg_rs2_data, reg_rd} !== {32'd5, 32'd7, 5'd3}) begin
      errors++;
      $display("FAIL rtype_data: got %0d %0d %0d expected 5 7 3",
               reg_rs1_data, reg_rs2_data, reg_rd);
    end
    checks++;
    if (reg_regWrite !== 1'b1 || reg_ALUOp !== 3'b000) begin
      errors++;
      $display("FAIL rtype_ctrl: got regWrite=%b ALUOp=%b expected 1 000",
               reg_regWrite, reg_ALUOp);
    end
  endtask

  task automatic test_opcode_sweep();
    for (int i = 0; i < 9; i++) begin
      opcode = OPS[i];
      rs1_data = 32'h1111_0000 + 32'(i);
      inst_PC = 20'h00100 + 20'(i * 4);
      #1;
      checks++;
      if (extend_sel !== EXP[i][1:0]) begin
        errors++;
        $display("FAIL sweep_extend_sel op=%b: got %b expected %b",
                 OPS[i], extend_sel, EXP[i][1:0]);
      end
      tick();
      checks++;
      if (got_ctrl !== EXP[i]) begin
        errors++;
        $display("FAIL sweep_ctrl op=%b: got %b expected %b",
                 OPS[i], got_ctrl, EXP[i]);
      end
      checks++;
      if (reg_opcode !== OPS[i] || reg_rs1_data !== 32'h1111_0000 + 32'(i)
          || reg_inst_PC !== 20'h00100 + 20'(i * 4)) begin
        errors++;
        $display("FAIL sweep_data op=%b: got op=%b rs1=%h pc=%h",
                 OPS[i], reg_opcode, reg_rs1_data, reg_inst_PC);
      end
    end
  endtask

  task automatic test_unknown_opcode();
    opcode = 7'b1111111; rs2_data = 32'hCAFE_F00D; rd = 5'd31;
    funct3 = 3'h2; funct7 = 7'h55;
    #1;
    checks++;
    if (extend_sel !== 2'b00) begin
      errors++;
      $display("FAIL nop_extend_sel: got %b expected 00", extend_sel);
    end
    tick();
    checks++;
    if (got_ctrl !== 15'd0) begin
      errors++;
      $display("FAIL nop_ctrl: got %b expected 0", got_ctrl);
    end
    checks++;
    if (reg_rs2_data !== 32'hCAFE_F00D || reg_rd !== 5'd31 ||
        reg_opcode !== 7'b1111111 || reg_funct3 !== 3'h2 ||
        reg_funct7 !== 7'h55) begin
      errors++;
      $display("FAIL nop_data: got rs2=%h rd=%0d op=%b f3=%h f7=%h",
               reg_rs2_data, reg_rd, reg_opcode, reg_funct3, reg_funct7);
    end
  endtask

  task automatic test_stall();
    opcode = 7'b0000011; inst_PC = 20'h00100; rs1_data = 32'h0000_00AA;
    tick();
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      opcode = 7'b0100011; inst_PC = 20'h00200 + 20'(c);
      rs1_data = 32'h0000_0BB0 + 32'(c);
      tick();
      checks++;
      if (reg_memRead !== 1'b1 || reg_inst_PC !== 20'h00100 ||
          reg_rs1_data !== 32'h0000_00AA || reg_memWrite !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got memRead=%b pc=%h rs1=%h memWrite=%b",
                 c, reg_memRead, reg_inst_PC, reg_rs1_data, reg_memWrite);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (reg_memWrite !== 1'b1 || reg_inst_PC !== 20'h00201) begin
      errors++;
      $display("FAIL stall_release: got memWrite=%b pc=%h expected 1 00201",
               reg_memWrite, reg_inst_PC);
    end
  endtask

  task automatic test_flush();
    opcode = 7'b1100011; branch_target = 20'h0FF00;
    tick();
    checks++;
    if (reg_branch_op !== 1'b1 || reg_branch_target !== 20'h0FF00) begin
      errors++;
      $display("FAIL flush_pre: got branch_op=%b target=%h expected 1 0ff00",
               reg_branch_op, reg_branch_target);
    end
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++;
    if (reg_branch_op !== 1'b0 || reg_next_PC_sel !== 2'b00 ||
        reg_regWrite !== 1'b0 || got_ctrl !== 15'd0) begin
      errors++;
      $display("FAIL flush_bubble: got ctrl=%b expected 0", got_ctrl);
    end
    checks++;
    if (got_data !== '0) begin
      errors++;
      $display("FAIL flush_data: got %h expected 0", got_data);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset_flush_jal();
    opcode = 7'b1101111; JAL_target = 20'h3C3C3;
    tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if (got_ctrl !== 15'd0 || reg_JAL_target !== 20'h0) begin
      errors++;
      $display("FAIL rst_flush_zero: got ctrl=%b jal=%h expected 0 0",
               got_ctrl, reg_JAL_target);
    end
    reset = 1'b0; flush = 1'b0; JAL_target = 20'h5A5A5;
    tick();
    checks++;
    if (reg_next_PC_sel !== 2'b10 || reg_operand_A_sel !== 2'b10 ||
        reg_JAL_target !== 20'h5A5A5) begin
      errors++;
      $display("FAIL jal_after: got npc=%b A=%b jal=%h expected 10 10 5a5a5",
               reg_next_PC_sel, reg_operand_A_sel, reg_JAL_target);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_opcode_sweep();
    test_unknown_opcode();
    test_stall();
    test_flush();
    test_reset_flush_jal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
